serial_logic_unit: RTL and testbench
====================================

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, result bits produced per RUN cycle; WIDTH % SLICE == 0.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operand request.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  3  operation code: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 reserved.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  bitwise result.
REQ-013 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE: in_ready=1; in_valid=1 SHALL latch a, b, op, clear slice counter and result register, go to RUN.
REQ-016 In RUN: each cycle SHALL compute SLICE bits, lowest unprocessed slice first (bits [SLICE-1:0] on first cycle), write them into the corresponding result positions, increment counter.
REQ-017 After WIDTH/SLICE RUN cycles SHALL enter DONE; acceptance-to-out_valid latency SHALL be exactly WIDTH/SLICE+1 cycles (9 at defaults).
REQ-018 In DONE: out_valid=1; result SHALL stay stable until out_valid&&out_ready, then return to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; a, b, op changes after acceptance SHALL not affect the in-flight result.
REQ-020 out_ready asserted outside DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored (not queued).
REQ-021 Reserved op codes 6-7 SHALL yield result all zeros with normal timing.
REQ-022 result SHALL read the partial register in RUN; consumers SHALL sample only when out_valid=1.
REQ-023 Next request SHALL be acceptable the cycle after DONE handshake (1 idle cycle minimum between results).

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter 0, result 0, out_valid 0, busy 0, in_ready 0 while rst_n low.
REQ-025 in_ready SHALL go 1 on the first clk edge after rst_n release.
REQ-026 Reset during RUN or DONE SHALL abort the operation; no partial result SHALL be delivered.

Configuration
REQ-027 Macro SERIAL_LOGIC_ZERO_FLAG_EN defined: SHALL add output zero (1 bit), registered with out_valid, =1 iff result==0, reset 0.
REQ-028 Macro undefined: zero port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold op-code constants (OP_AND..OP_XNOR), op typedef (3 bits), FSM state typedef.
REQ-030 Sub-module logic_slice SHALL compute SLICE result bits from SLICE-bit A, B slices and op, combinationally; instantiated once.

Verification
REQ-031 Reset, then a=32'hF0F0_0000, b=32'h0F0F_00FF, op=1 -> out_valid 9 cycles after acceptance, result=32'hFFFF_00FF.
REQ-032 a=32'hFFFF_FFFF, b=32'h1234_5678, op=2 -> result=32'hEDCB_A987; with ZERO_FLAG_EN zero=0.
REQ-033 op=0, a=32'hAAAA_AAAA, b=32'h5555_5555 with out_ready held 0 for 5 cycles -> result 0 stable, out_valid held; with ZERO_FLAG_EN zero=1.
REQ-034 Accept op=4 (a=0, b=0), change a/b/op every cycle during RUN -> result=32'hFFFF_FFFF unchanged by new inputs; in_ready=0 throughout.
REQ-035 rst_n low for 1 cycle at RUN cycle 4 -> out_valid never rises; busy=0, result=0; next request completes normally.
REQ-036 op=7, any a/b -> result=0 after 9 cycles; back-to-back requests with out_ready=1 -> one result per 10 cycles.

Source files
------------

// File: rtl/serial_logic_unit_pkg.sv
// Shared definitions for the serial logic unit.
//   op_t     : 3-bit operation code, with constants OP_AND..OP_XNOR (6-7 reserved)
//   state_e  : control FSM states (idle, run, done)
package serial_logic_unit_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_AND  = 3'd0;
   localparam op_t OP_OR   = 3'd1;
   localparam op_t OP_XOR  = 3'd2;
   localparam op_t OP_NAND = 3'd3;
   localparam op_t OP_NOR  = 3'd4;
   localparam op_t OP_XNOR = 3'd5;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operator over one SLICE-bit chunk of the operands.
//   a_i, b_i : operand slices
//   op_i     : operation code; reserved codes give all zeros
//   res_o    : slice result
module logic_slice
   import serial_logic_unit_pkg::*;
#(
   parameter int unsigned SLICE = 4
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  op_t              op_i,
   output logic [SLICE-1:0] res_o
);

   always_comb begin
      res_o = '0;
      unique case (op_i)
         OP_AND:  res_o = a_i & b_i;
         OP_OR:   res_o = a_i | b_i;
         OP_XOR:  res_o = a_i ^ b_i;
         OP_NAND: res_o = ~(a_i & b_i);
         OP_NOR:  res_o = ~(a_i | b_i);
         OP_XNOR: res_o = ~(a_i ^ b_i);
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/serial_logic_unit.sv
// Serial bitwise logic unit: computes a WIDTH-bit bitwise op SLICE bits per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand request handshake (a, b, op)
//   out_valid / out_ready: result handshake (result)
//   busy                 : high while an operation is running or awaiting pickup
//   zero                 : result-is-zero flag, present only when
//                          SERIAL_LOGIC_ZERO_FLAG_EN is defined
module serial_logic_unit
   import serial_logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int unsigned NumSlices = WIDTH / SLICE;
   localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   op_t              op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic [31:0]      base;
   logic [SLICE-1:0] slice_res;

   assign base = SLICE * 32'(cnt_q);

   logic_slice #(
      .SLICE (SLICE)
   ) u_logic_slice (
      .a_i   (a_q[base +: SLICE]),
      .b_i   (b_q[base +: SLICE]),
      .op_i  (op_q),
      .res_o (slice_res)
   );

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
   logic zero_q, zero_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      result_d    = result_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      zero_d      = zero_q;
`endif
      unique case (state_q)
         StIdle: begin
            // in_ready_q is low for the first cycle after reset release
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               a_d        = a;
               b_d        = b;
               op_d       = op;
               cnt_d      = '0;
               result_d   = '0;
               state_d    = StRun;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         StRun: begin
            result_d[base +: SLICE] = slice_res;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               cnt_d       = '0;
               state_d     = StDone;
               out_valid_d = 1'b1;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
               zero_d      = (result_d == '0);
`endif
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d     = StIdle;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
               zero_d      = 1'b0;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= OP_AND;
         result_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
         zero_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         result_q    <= result_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
         zero_q      <= zero_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
   assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit at default parameters.
module tb_serial_logic_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
   logic        zero;
`endif

   int errors = 0;
   int checks = 0;

   serial_logic_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      ,
      .zero      (zero)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Whole-word reference: the result is just the bitwise op on full operands.
   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] o);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x & y);
         3'd4:    return ~(x | y);
         3'd5:    return ~(x ^ y);
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts #1 after a posedge with the unit idle and ready.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [2:0] top, input int hold, input bit scramble);
      logic [31:0] exp;
      logic [31:0] held;
      int          lat;
      exp       = model(ta, tb_v, top);
      a         = ta;
      b         = tb_v;
      op        = top;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      lat      = 1;
      in_valid = 1'b0;
      while (!out_valid && lat < 30) begin
         chk({tag, " in_ready_run"}, 32'(in_ready), 32'd0);
         chk({tag, " busy_run"}, 32'(busy), 32'd1);
         if (scramble) begin
            a         = $urandom;
            b         = $urandom;
            op        = 3'($urandom_range(0, 7));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'd9);
      chk({tag, " result"}, result, exp);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      chk({tag, " zero"}, 32'(zero), 32'(exp == 32'h0));
`endif
      held = result;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, " hold_result"}, result, held);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, " ready_after"}, 32'(in_ready), 32'd1);
      chk({tag, " busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int first_rise;
      int second_rise;
      int waited;
      bit seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      op        = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst result", result, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("release in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("first edge in_ready", 32'(in_ready), 32'd1);

      run_op("or", 32'hF0F0_0000, 32'h0F0F_00FF, 3'd1, 0, 1'b0);
      chk("or const", model(32'hF0F0_0000, 32'h0F0F_00FF, 3'd1), 32'hFFFF_00FF);
      run_op("xor", 32'hFFFF_FFFF, 32'h1234_5678, 3'd2, 1, 1'b0);
      run_op("and_hold", 32'hAAAA_AAAA, 32'h5555_5555, 3'd0, 5, 1'b0);
      run_op("nor_scramble", 32'h0, 32'h0, 3'd4, 2, 1'b1);
      run_op("reserved", $urandom, $urandom, 3'd7, 0, 1'b0);

      // Reset in the middle of RUN must abort without delivering anything.
      a        = 32'h1234_5678;
      b        = 32'h0F0F_0F0F;
      op       = 3'd2;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort result", result, 32'h0);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort in_ready", 32'(in_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort ready_back", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      chk("abort no_valid", 32'(seen), 32'd0);
      run_op("after_abort", 32'hDEAD_BEEF, 32'h0000_FFFF, 3'd0, 1, 1'b0);

      for (int n = 0; n < 6; n++) begin
         run_op($sformatf("rand%0d", n), $urandom, $urandom, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), 1'b1);
      end

      // Back-to-back reserved ops with the consumer always ready.
      first_rise  = -1;
      second_rise = -1;
      op          = 3'd7;
      a           = $urandom;
      b           = $urandom;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (out_valid) begin
            chk("b2b result", result, 32'h0);
            if (first_rise < 0) first_rise = c;
            else if (second_rise < 0) second_rise = c;
         end
      end
      in_valid = 1'b0;
      chk("b2b first", 32'(first_rise), 32'd9);
      chk("b2b period", 32'(second_rise - first_rise), 32'd10);
      waited = 0;
      while (!in_ready && waited < 30) begin
         tick();
         waited++;
      end
      chk("b2b drain", 32'(in_ready), 32'd1);
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
